// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line conditioner.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_e;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer, FILTER-sample debounce and falling-edge detect for one PS/2 line.
module ps2_line_sync #(
  parameter int unsigned FILTER = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic filt_o,
  output logic fall_c
);

  localparam int unsigned CNT_W = $clog2(FILTER + 1);

  logic             s1_q, s2_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_d;

  // Count consecutive synced samples that disagree with the filtered level.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (s2_q != filt_q) begin
      if (cnt_q == CNT_W'(FILTER - 1)) begin
        filt_d = s2_q;
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer and filter state; idle bus level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign fall_c = fall_d;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8N1+odd frame, ACK check.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_CYC = 750000,
  parameter int unsigned FILTER      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int unsigned INHIBIT_CYC = CLK_FREQ / 1000000 * INHIBIT_US;
  localparam int unsigned CNT_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d, bit_next;
  logic [7:0]       shreg_q, shreg_d;
  logic             parity_q, parity_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             to_err_q, to_err_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             dat_s1_q, dat_s2_q;
  logic             fclk, fall;
  logic             timeout_hit;

  ps2_line_sync #(.FILTER(FILTER)) u_clk_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (ps2_clk_in),
    .filt_o (fclk),
    .fall_c (fall)
  );

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    parity_d    = parity_q;
    clk_oe_d    = clk_oe_q;
    dat_oe_d    = dat_oe_q;
    done_d      = 1'b0;
    ack_err_d   = 1'b0;
    to_err_d    = 1'b0;
    bit_next    = bitcnt_q + 4'd1;
    timeout_hit = (state_q inside {ST_REQ, ST_SEND, ST_ACK, ST_WAIT_IDLE}) &&
                  (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          shreg_d  = tx_data;
          parity_d = odd_parity(tx_data);
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          bitcnt_d = 4'd0;
          state_d  = ST_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REQ, ST_SEND: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fall) begin
          bitcnt_d = bit_next;
          state_d  = ST_SEND;
          if (bit_next <= 4'd8) begin
            dat_oe_d = ~shreg_q[bitcnt_q[2:0]];
          end else if (bit_next == 4'd9) begin
            dat_oe_d = ~parity_q;
          end else begin
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fall) begin
          if (dat_s2_q) begin
            ack_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fclk && dat_s2_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // Timeout overrides any bit activity in the same cycle.
    if (timeout_hit) begin
      state_d   = ST_IDLE;
      clk_oe_d  = 1'b0;
      dat_oe_d  = 1'b0;
      done_d    = 1'b0;
      ack_err_d = 1'b0;
      to_err_d  = 1'b1;
      cnt_d     = '0;
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, counters, data-line synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= 4'd0;
      shreg_q   <= 8'd0;
      parity_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      to_err_q  <= to_err_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      dat_s1_q  <= ps2_dat_in;
      dat_s2_q  <= dat_s1_q;
    end
  end

  assign tx_ready    = ready_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_dat_oe  = dat_oe_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device, frame model and pulse monitors.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned CLK_FREQ    = 50000000;
  localparam int unsigned INHIBIT_US  = 100;
  localparam int unsigned TIMEOUT_CYC = 3000;
  localparam int unsigned FILTER      = 8;
  localparam int          INHIBIT_EXP = 5000;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_RESET  = 3;
  localparam int M_GLITCH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout_err;
  logic       dev_clk, dev_dat_low;
  logic       ps2_clk_line, ps2_dat_line;

  int errors = 0;
  int checks = 0;
  int n_done = 0, n_ack = 0, n_to = 0;
  int viol_excl = 0, viol_ready = 0, viol_both = 0;
  logic prev_pulse = 1'b0;

  assign ps2_clk_line = ~ps2_clk_oe & dev_clk;
  assign ps2_dat_line = ~ps2_dat_oe & ~dev_dat_low;

  ps2_host_tx #(
    .CLK_FREQ(CLK_FREQ), .INHIBIT_US(INHIBIT_US),
    .TIMEOUT_CYC(TIMEOUT_CYC), .FILTER(FILTER)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_line), .ps2_dat_in(ps2_dat_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy),
    .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Pulse counting and always-true properties, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) n_done++;
      if (ack_err) n_ack++;
      if (timeout_err) n_to++;
      if ((int'(done) + int'(ack_err) + int'(timeout_err)) > 1) viol_excl++;
      if (prev_pulse && !(tx_ready && !busy)) viol_ready++;
      if (ps2_clk_oe && ps2_dat_oe) viol_both++;
      prev_pulse = done | ack_err | timeout_err;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame as the device sees it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = d[k];
    f[9]  = (($countones(d) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send_req(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Behavioural keyboard: waits for the start bit, clocks 11 periods, reads on rises.
  task automatic dev_frame(input int mode, input int h, output logic [10:0] bits);
    logic ok;
    bits = '0;
    ok   = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_dat_oe) begin
        ok = 1'b1;
        break;
      end
    end
    chk("start_bit_seen", 32'(ok), 32'd1);
    if (!ok) return;
    bits[0] = ps2_dat_line;
    repeat (h) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      if (mode == M_GLITCH && i == 2) begin
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
      end
      if (i == 10) tx_valid = 1'b0;
      if (mode == M_GLITCH && i == 5) begin
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (h) @(negedge clk);
      end
      dev_clk = 1'b0;
      if (mode == M_RESET && i == 4) begin
        repeat (h / 2) @(negedge clk);
        chk("dat_driven_before_reset", 32'(ps2_dat_oe), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_frame_lines", 32'({ps2_clk_oe, ps2_dat_oe, tx_ready, busy}), 32'b0010);
        reset   = 1'b0;
        dev_clk = 1'b1;
        return;
      end
      repeat (h) @(negedge clk);
      if (i <= 10) bits[i] = ps2_dat_line;
      dev_clk = 1'b1;
      if (i == 10 && mode != M_NOACK) dev_dat_low = 1'b1;
      if (i == 11) dev_dat_low = 1'b0;
      repeat (h) @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d, input logic [10:0] bits,
                             input int d0, input int a0, input int t0,
                             input logic exp_done, input logic exp_ack);
    repeat (5) @(negedge clk);
    chk({tag, "_bits"}, 32'(bits), 32'(frame_bits(d)));
    chk({tag, "_done"}, 32'(n_done - d0), 32'(exp_done));
    chk({tag, "_ack_err"}, 32'(n_ack - a0), 32'(exp_ack));
    chk({tag, "_timeout"}, 32'(n_to - t0), 32'd0);
    chk({tag, "_idle_lines"}, 32'({ps2_clk_oe, ps2_dat_oe, tx_ready, busy}), 32'b0010);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input int mode, input int h,
                           input logic exp_done, input logic exp_ack);
    int d0, a0, t0;
    logic [10:0] bits;
    d0 = n_done; a0 = n_ack; t0 = n_to;
    send_req(d);
    dev_frame(mode, h, bits);
    check_frame(tag, d, bits, d0, a0, t0, exp_done, exp_ack);
  endtask

  typedef struct {
    logic [7:0] data;
    int         mode;
    int         h;
    logic       exp_done;
    logic       exp_ack;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int d0, a0, t0, n;
    logic [10:0] bits;
    logic [7:0]  rd;
    int          rm;

    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk = 1'b1; dev_dat_low = 1'b0;

    tbl[0] = '{PS2_CMD_SETLED, M_ACK,   40, 1'b1, 1'b0};
    tbl[1] = '{PS2_CMD_ENABLE, M_ACK,   55, 1'b1, 1'b0};
    tbl[2] = '{8'hA5,          M_NOACK, 40, 1'b0, 1'b1};
    tbl[3] = '{8'h01,          M_ACK,   25, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_state", 32'({tx_ready, busy, ps2_clk_oe, ps2_dat_oe, done, ack_err, timeout_err}),
        32'b1000000);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Table-driven frames.
    for (int i = 0; i < 4; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].mode, tbl[i].h,
                tbl[i].exp_done, tbl[i].exp_ack);

    // Inhibit length and accept latency with 0x00 (parity bit 1).
    d0 = n_done; a0 = n_ack; t0 = n_to;
    send_req(8'h00);
    chk("accept_busy_clk_oe", 32'({busy, tx_ready, ps2_clk_oe, ps2_dat_oe}), 32'b1010);
    n = 0;
    while (ps2_clk_oe && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk("inhibit_cycles", 32'(n), 32'(INHIBIT_EXP));
    chk("start_bit_after_inhibit", 32'(ps2_dat_oe), 32'd1);
    dev_frame(M_ACK, 40, bits);
    check_frame("zero", 8'h00, bits, d0, a0, t0, 1'b1, 1'b0);

    // Silent device: timeout counted from REQ entry.
    d0 = n_done; a0 = n_ack; t0 = n_to;
    send_req(PS2_CMD_RESET);
    n = 0;
    while (ps2_clk_oe && n < 20000) begin
      n++;
      @(negedge clk);
    end
    n = 0;
    while (!timeout_err && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", 32'(n), 32'(TIMEOUT_CYC));
    chk("timeout_lines_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
    repeat (2) @(negedge clk);
    chk("timeout_pulses", 32'({n_done - d0, n_ack - a0, n_to - t0}), {32'd0, 32'd0, 32'd1});
    chk("timeout_ready", 32'(tx_ready), 32'd1);

    // Reset after fall 4, then a clean 0xFF frame.
    d0 = n_done; a0 = n_ack; t0 = n_to;
    send_req(8'h33);
    dev_frame(M_RESET, 40, bits);
    repeat (30) @(negedge clk);
    chk("reset_no_pulses", 32'((n_done - d0) + (n_ack - a0) + (n_to - t0)), 32'd0);
    run_frame("after_reset", PS2_CMD_RESET, M_ACK, 40, 1'b1, 1'b0);

    // Clock glitch and a request made while busy.
    run_frame("glitch", 8'hC3, M_GLITCH, 40, 1'b1, 1'b0);

    // Randomized frames against the model.
    for (int i = 0; i < 3; i++) begin
      rd = 8'($urandom);
      rm = int'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d", i), rd, rm, int'($urandom_range(25, 60)),
                rm == M_ACK, rm == M_NOACK);
    end

    chk("pulse_exclusive", 32'(viol_excl), 32'd0);
    chk("ready_after_pulse", 32'(viol_ready), 32'd0);
    chk("clk_dat_oe_together", 32'(viol_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
